// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: buffers upstream samples in a small FIFO and hands one
// to the DAC core on each val_req pulse. A FILL/RUN state machine holds off
// playback until the FIFO has prefilled; an empty-FIFO request in RUN is an
// underrun that holds the last value, is counted and returns to FILL.
module dac_sample_feeder #(
    parameter int unsigned         DAC_BITS    = 14,
    parameter int unsigned         DEPTH_LOG2  = 4,
    parameter int unsigned         START_LEVEL = 8,
    parameter logic [DAC_BITS-1:0] IDLE_VAL    = 14'h2000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DAC_BITS-1:0]   s_data,
    input  logic                  val_req,
    output logic [DAC_BITS-1:0]   dac_val,
    output logic                  running,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underrun,
    output logic [15:0]           underrun_cnt,
    input  logic                  cnt_clr
);

    localparam int unsigned         DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] START_LVL = (DEPTH_LOG2 + 1)'(START_LEVEL);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q;
    logic [DAC_BITS-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic [DAC_BITS-1:0]     dac_val_q;
    logic                    underrun_q;
    logic [15:0]             cnt_q, cnt_d;

    logic                    s_ready_c;
    logic                    push;
    logic                    req_run;
    logic                    pop;
    logic                    urun;

    // Handshake decode, pointer/level/counter next-state.
    // Pop and underrun are judged on the pre-edge level, so a push landing on
    // an empty FIFO in the same cycle as a request is still an underrun.
    always_comb begin
        s_ready_c = (level_q != FULL_LVL);
        push      = s_valid && s_ready_c;
        req_run   = (state_q == RUN) && val_req;
        pop       = req_run && (level_q != '0);
        urun      = req_run && (level_q == '0);

        wr_ptr_d  = wr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        rd_ptr_d  = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        level_d   = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        cnt_d     = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (urun && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Sample storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // FIFO pointers, occupancy and underrun counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
        end
    end

    // FILL/RUN state machine with registered sample and underrun pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= FILL;
            dac_val_q  <= IDLE_VAL;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (level_q >= START_LVL) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (pop) begin
                        dac_val_q <= mem_q[rd_ptr_q];
                    end else if (urun) begin
                        underrun_q <= 1'b1;
                        state_q    <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign s_ready      = s_ready_c;
    assign dac_val      = dac_val_q;
    assign running      = (state_q == RUN);
    assign level        = level_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Bench for dac_sample_feeder: directed phases plus a random phase, checked
// against a queue-based reference model. Every request queues its expected
// response; a monitor pops and compares one cycle after each request.
module tb_dac_sample_feeder;

    localparam int START = 8;
    localparam int DEPTH = 16;

    logic        clk;
    logic        rstn;
    logic        s_valid;
    logic        s_ready;
    logic [13:0] s_data;
    logic        val_req;
    logic [13:0] dac_val;
    logic        running;
    logic [4:0]  level;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic        cnt_clr;

    dac_sample_feeder #(
        .DAC_BITS    (14),
        .DEPTH_LOG2  (4),
        .START_LEVEL (START),
        .IDLE_VAL    (14'h2000)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .val_req      (val_req),
        .dac_val      (dac_val),
        .running      (running),
        .level        (level),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .cnt_clr      (cnt_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [13:0] dac;
        logic        und;
        logic [15:0] cnt;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          acc_cnt = 0;

    // Reference model state
    logic [13:0] mq[$];
    exp_t        expq[$];
    logic        m_run;
    logic [13:0] m_dac;
    logic [15:0] m_cnt;
    logic        m_und;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        expq.delete();
        m_run = 1'b0;
        m_dac = 14'h2000;
        m_cnt = '0;
        m_und = 1'b0;
    endtask

    // One clock edge of the reference behaviour, from pre-edge state.
    task automatic model_step(input logic v, input logic [13:0] d, input logic r, input logic c);
        int   n;
        logic pu;
        exp_t e;
        n     = mq.size();
        pu    = v && (n != DEPTH);
        m_und = 1'b0;
        if (m_run) begin
            if (r) begin
                if (n > 0) begin
                    m_dac = mq.pop_front();
                end else begin
                    m_und = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    m_run = 1'b0;
                end
            end
        end else if (n >= START) begin
            m_run = 1'b1;
        end
        if (c) m_cnt = '0;
        if (pu) mq.push_back(d);
        if (r) begin
            e.dac = m_dac;
            e.und = m_und;
            e.cnt = m_cnt;
            expq.push_back(e);
        end
    endtask

    // One cycle: check settled outputs, then drive inputs for the next edge.
    task automatic cyc(input logic v, input logic [13:0] d, input logic r, input logic c);
        @(negedge clk);
        chk("level",    32'(level),        32'(mq.size()));
        chk("running",  32'(running),      32'(m_run));
        chk("s_ready",  32'(s_ready),      32'(mq.size() != DEPTH));
        chk("underrun", 32'(underrun),     32'(m_und));
        chk("dac_val",  32'(dac_val),      32'(m_dac));
        chk("cnt",      32'(underrun_cnt), 32'(m_cnt));
        if (v && s_ready) acc_cnt++;
        s_valid = v;
        s_data  = d;
        val_req = r;
        cnt_clr = c;
        model_step(v, d, r, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic push_n(input int n, input logic [13:0] base);
        for (int i = 0; i < n; i++) cyc(1'b1, base + 14'(i), 1'b0, 1'b0);
    endtask

    task automatic drain_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            idle(gap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        val_req = 1'b0;
        cnt_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Scoreboard monitor: every request is answered one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rstn && val_req) begin
                #1;
                if (expq.size() == 0) begin
                    chk("sb_empty", 32'(expq.size()), 32'd1);
                end else begin
                    e = expq.pop_front();
                    chk("sb_dac",      32'(dac_val),      32'(e.dac));
                    chk("sb_underrun", 32'(underrun),     32'(e.und));
                    chk("sb_cnt",      32'(underrun_cnt), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pv;
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        val_req = 1'b0;
        cnt_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_dac",     32'(dac_val),      32'h2000);
        chk("rst_level",   32'(level),        32'd0);
        chk("rst_running", 32'(running),      32'd0);
        chk("rst_sready",  32'(s_ready),      32'd1);
        chk("rst_cnt",     32'(underrun_cnt), 32'd0);
        rstn = 1'b1;

        // Idle after reset, requests ignored in FILL
        for (int i = 0; i < 40; i++) cyc(1'b0, '0, (i % 4) == 0, 1'b0);

        // Prefill 1..8, then ordered playback, then underrun
        push_n(8, 14'h0001);
        idle(2);
        drain_n(8, 15);
        drain_n(1, 2);
        drain_n(3, 3);

        // Fill to full under backpressure, then one request frees a slot
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) cyc(1'b1, 14'h0100 + 14'(acc_cnt), 1'b0, 1'b0);
        chk("accepted", 32'(acc_cnt), 32'd16);
        cyc(1'b1, 14'h0100 + 14'(acc_cnt), 1'b1, 1'b0);
        cyc(1'b1, 14'h0100 + 14'(acc_cnt), 1'b0, 1'b0);
        idle(2);
        chk("accepted17", 32'(acc_cnt), 32'd17);
        drain_n(16, 2);
        drain_n(1, 2);

        // Push into empty FIFO together with a request in RUN
        push_n(8, 14'h0200);
        idle(2);
        drain_n(8, 1);
        cyc(1'b1, 14'h1234, 1'b1, 1'b0);
        idle(2);
        // Counter clear coinciding with an underrun
        push_n(7, 14'h0300);
        idle(2);
        drain_n(8, 1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        idle(2);

        // Random traffic with varying producer rate
        for (int i = 0; i < 800; i++) begin
            pv = ((i / 100) % 2 == 0) ? 30 : 75;
            cyc($urandom_range(0, 99) < pv, 14'($urandom), $urandom_range(0, 2) == 0,
                $urandom_range(0, 40) == 0);
        end
        idle(3);

        // Asynchronous reset with five samples buffered in RUN
        do_reset();
        push_n(8, 14'h0500);
        idle(2);
        drain_n(3, 0);
        idle(1);
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_level",   32'(level),   32'd5);
        chk("pre_rst_running", 32'(running), 32'd1);
        #3;
        rstn = 1'b0;
        #1;
        chk("async_rst_dac",     32'(dac_val), 32'h2000);
        chk("async_rst_level",   32'(level),   32'd0);
        chk("async_rst_running", 32'(running), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        push_n(10, 14'h0A00);
        idle(2);
        drain_n(12, 1);
        idle(3);
        chk("sb_drained", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_sample_feeder.md
Name: dac_sample_feeder

Overview:
- Responder/source side of the DAC value-request interface: on each one-cycle `val_req` pulse from the R2R+PWM DAC core it presents the next sample on `dac_val`.
- Samples arrive from an upstream generator (NCO, waveform RAM, UART loader) over a valid/ready stream and are buffered in an internal FIFO.
- A prefill state machine decouples bursty producers from the DAC's fixed request rate.
- Underruns are handled by holding the last value and counting the event.

Parameters:
- `DAC_BITS`, 14, sample width; equals R2R_BITS + PWM_BITS of the DAC core.
- `DEPTH_LOG2`, 4, FIFO depth = 2**DEPTH_LOG2 entries.
- `START_LEVEL`, 8, FIFO occupancy required to leave FILL; legal range 1..2**DEPTH_LOG2.
- `IDLE_VAL`, 14'h2000, value driven on `dac_val` after reset (mid-scale).

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  feeder can accept a sample.
- `s_data`  in  DAC_BITS  upstream sample.
- `val_req`  in  1  one-cycle request strobe from DAC core.
- `dac_val`  out  DAC_BITS  registered sample to DAC core.
- `running`  out  1  1 = RUN state, 0 = FILL state.
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2.
- `underrun`  out  1  one-cycle pulse on an underrun event.
- `underrun_cnt`  out  16  saturating underrun event count.
- `cnt_clr`  in  1  synchronous clear of `underrun_cnt`.

Behaviour:
- Reset (`rstn` low, asynchronous, any cycle including mid-burst):
  - `dac_val` = IDLE_VAL; `level` = 0; `running` = 0; `underrun` = 0; `underrun_cnt` = 0; FIFO pointers = 0.
  - `s_ready` = 1 after reset.
  - Buffered contents are discarded.
- Write side:
  - `s_ready` = (`level` != 2**DEPTH_LOG2), decoded combinationally from registered `level`.
  - Push when `s_valid` && `s_ready`.
  - `s_data` is written at the write pointer; the pointer wraps modulo depth.
- FIFO storage is registers or distributed RAM. Pointers are DEPTH_LOG2 bits. `level` is an explicit counter.
- State machine FILL (reset state) / RUN:
  - FILL:
    - `val_req` is ignored: no pop, `dac_val` holds, no underrun counted.
    - Go to RUN on the edge where registered `level` >= START_LEVEL.
  - RUN, `val_req`=1 and `level` > 0:
    - `dac_val` <= FIFO head on that edge; pop.
    - Latency: new value visible the cycle after `val_req`.
  - RUN, `val_req`=1 and `level` == 0 (underrun):
    - `dac_val` holds its last value.
    - `underrun` pulses high for one cycle (the cycle after the request).
    - `underrun_cnt` increments, saturating at 16'hFFFF.
    - State returns to FILL.
  - RUN, `val_req`=0: hold.
- Simultaneous events:
  - Push and pop on the same edge: `level` unchanged; both pointers advance.
  - Push into an empty FIFO on the same edge as `val_req` in RUN: no bypass. This is an underrun. The pushed sample is stored, `level` becomes 1, state becomes FILL.
  - `cnt_clr` and an underrun on the same edge: clear wins, `underrun_cnt` = 0.
  - `level` reaching START_LEVEL and `val_req` on the same edge in FILL: the request is ignored; RUN begins next cycle.
- Ordering: samples leave in exact push order. No sample is dropped or duplicated except the hold-on-underrun behaviour.
- Widths: `level` counts 0..2**DEPTH_LOG2 inclusive, so full and empty are unambiguous. No arithmetic is applied to sample data.

Test Plan:
- Reset behaviour:
  - Stimulus: deassert `rstn`, no stimulus, pulse `val_req` every 4 cycles for 40 cycles.
  - Required: `dac_val` = 14'h2000, `running` = 0, `underrun_cnt` = 0, `s_ready` = 1 throughout.
- Prefill then ordered playback:
  - Stimulus: push 14'h0001..14'h0008; then `val_req` every 16 cycles.
  - Required: `running` rises the cycle after the 8th push; `dac_val` steps 1,2,...,8, each one cycle after its `val_req`; `level` returns to 0.
- Full and backpressure:
  - Stimulus: hold `s_valid` = 1 with incrementing data, no requests.
  - Required: exactly 16 accepted; `s_ready` = 0 at `level` = 16.
  - Then one `val_req`: `s_ready` = 1 next cycle and the 17th word is accepted; the pop and push edge leave `level` = 16.
- Underrun:
  - Stimulus: after playback drains to empty, pulse `val_req`.
  - Required: `dac_val` holds 14'h0008; `underrun` is a one-cycle pulse; `underrun_cnt` = 1; `running` = 0.
  - Further `val_req` pulses in FILL leave `underrun_cnt` = 1.
- Simultaneous events:
  - Stimulus: at `level` = 0 in RUN, assert push 14'h1234 and `val_req` on the same edge.
  - Required: underrun counted, `level` = 1, `dac_val` unchanged.
  - Stimulus: `cnt_clr` together with a further underrun.
  - Required: `underrun_cnt` = 0.
- Reset mid-operation:
  - Stimulus: assert `rstn` low asynchronously with `level` = 5 in RUN.
  - Required: immediately `dac_val` = 14'h2000, `level` = 0, `running` = 0; old samples never appear after release.
